instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/cop_pkg.sv | 22 ++
 rtl/instr_sequencer_if.sv | 34 +++
 rtl/seq_prog_ram.sv | 26 ++
 rtl/instr_sequencer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cop_pkg.sv
// Shared constants and FSM state type for the instruction sequencer.
// Build option: SEQ_LOOP_EN makes the program repeat until abort or HALT.
package cop_pkg;

  localparam int INSTR_W = 22;
  localparam int OP_MSB = 3;
  localparam int OP_LSB = 0;
  localparam logic [OP_MSB-OP_LSB:0] OP_HALT = '0;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_ISSUE = 3'd2;
  localparam state_t S_WAIT  = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  function automatic logic is_halt(input logic [INSTR_W-1:0] w);
    return w[OP_MSB:OP_LSB] == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Program-load, control and coprocessor-issue bundle of the sequencer.
// master drives program/control; slave is the sequencer itself.
interface instr_sequencer_if
  import cop_pkg::*;
#(
  parameter int AW = 4
);

  logic               prog_we;
  logic [AW-1:0]      prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic [AW:0]        prog_len;
  logic               start;
  logic               abort;
  logic               cop_ready;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               busy;
  logic               done;
  logic [AW-1:0]      pc;

  modport master (
    output prog_we, prog_addr, prog_data, prog_len,
    output start, abort, cop_ready,
    input  instr_out, instr_valid, busy, done, pc
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len,
    input  start, abort, cop_ready,
    output instr_out, instr_valid, busy, done, pc
  );

endinterface

// File: rtl/seq_prog_ram.sv
// Program buffer: one write port, one registered read port.
// Contents are deliberately not reset.
module seq_prog_ram
  import cop_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // write port and synchronous read port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetches words from a program buffer and issues them to a coprocessor.
// Build option: SEQ_LOOP_EN restarts at address 0 after the last word.
module instr_sequencer
  import cop_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int GAP = 4
) (
  input  logic             clk,
  input  logic             rst,
  instr_sequencer_if.slave bus
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L = (AW+1)'(1);
  localparam logic [7:0] GAP_L = 8'(GAP);

  state_t             state;
  logic [AW-1:0]      pc;
  logic [AW:0]        len;
  logic [7:0]         cnt;
  logic [INSTR_W-1:0] word;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;
  logic               done_q;

  logic               idle_like;
  logic               wr_en;
  logic               rd_en;
  logic               last;
  logic [AW:0]        len_c;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign wr_en = bus.prog_we && idle_like && !bus.abort;
  assign rd_en = (state == S_FETCH);
  assign len_c = (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;
  assign last = ({1'b0, pc} == (len - ONE_L));

  assign bus.instr_out = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.busy = !idle_like;
  assign bus.done = done_q;
  assign bus.pc = pc;

  seq_prog_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(bus.prog_addr),
    .wdata(bus.prog_data),
    .re   (rd_en),
    .raddr(pc),
    .rdata(word)
  );

  // sequencing FSM; strobes default low, abort overrides everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      len     <= '0;
      cnt     <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (bus.abort) begin
        state <= S_IDLE;
      end else begin
        unique case (1'b1)
          idle_like: begin
            if (bus.start) begin
              len <= len_c;
              pc  <= '0;
              if (len_c == '0) begin
                state  <= S_DONE;
                done_q <= 1'b1;
              end else begin
                state <= S_FETCH;
              end
            end
          end
          (state == S_FETCH): begin
            state <= S_ISSUE;
          end
          (state == S_ISSUE): begin
            if (is_halt(word)) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else if (bus.cop_ready) begin
              instr_q <= word;
              valid_q <= 1'b1;
              cnt     <= GAP_L;
              state   <= S_WAIT;
            end
          end
          (state == S_WAIT): begin
            if (cnt == 8'd1) begin
              cnt <= '0;
              if (last) begin
`ifdef SEQ_LOOP_EN
                pc    <= '0;
                state <= S_FETCH;
`else
                state  <= S_DONE;
                done_q <= 1'b1;
`endif
              end else begin
                pc    <= pc + 1'b1;
                state <= S_FETCH;
              end
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
